// File: rtl/ahb_mux_s2m.sv
// AHB slave-to-master return path: address decode to one-hot slave selects,
// data-phase owner tracking, read-data/ready/response return mux, and a
// default slave that answers unmapped accesses with a two-cycle ERROR.
module ahb_mux_s2m #(
  parameter logic [31:0] S1_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE = 32'h1000_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S3_BASE = 32'h2000_0000,
  parameter logic [31:0] S3_MASK = 32'hFFFF_0000
) (
  input  logic        H_clk,
  input  logic        H_rst,
  input  logic [31:0] H_addr_i,
  input  logic [1:0]  H_trans_i,
  input  logic [31:0] H_rdata_s1,
  input  logic [31:0] H_rdata_s2,
  input  logic [31:0] H_rdata_s3,
  input  logic        H_ready_s1,
  input  logic        H_ready_s2,
  input  logic        H_ready_s3,
  input  logic [1:0]  H_resp_s1,
  input  logic [1:0]  H_resp_s2,
  input  logic [1:0]  H_resp_s3,
  output logic        H_sel_s1,
  output logic        H_sel_s2,
  output logic        H_sel_s3,
  output logic [31:0] H_rdata_o,
  output logic        H_ready_o,
  output logic [1:0]  H_resp_o
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    DSEL_NONE,
    DSEL_S1,
    DSEL_S2,
    DSEL_S3,
    DSEL_DEF
  } dsel_t;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  dsel_t     dsel_q, dsel_d;
  ds_state_t ds_q, ds_d;

  logic hit_s1, hit_s2, hit_s3;
  logic active;
  logic unmapped_capture;

  // Address-only decode; S1 > S2 > S3 on overlap keeps the selects one-hot.
  always_comb begin
    hit_s1   = (H_addr_i & S1_MASK) == S1_BASE;
    hit_s2   = (H_addr_i & S2_MASK) == S2_BASE;
    hit_s3   = (H_addr_i & S3_MASK) == S3_BASE;
    H_sel_s1 = hit_s1;
    H_sel_s2 = hit_s2 & ~hit_s1;
    H_sel_s3 = hit_s3 & ~hit_s1 & ~hit_s2;
  end

  // NONSEQ and SEQ both have trans[1] set; IDLE and BUSY carry no address phase.
  assign active           = H_trans_i[1];
  assign unmapped_capture = H_ready_o & active & ~(hit_s1 | hit_s2 | hit_s3);

  // Next data-phase owner: only re-sampled when the current data phase completes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    dsel_d = dsel_q;
    if (H_ready_o) begin
      if (!active)       dsel_d = DSEL_NONE;
      else if (H_sel_s1) dsel_d = DSEL_S1;
      else if (H_sel_s2) dsel_d = DSEL_S2;
      else if (H_sel_s3) dsel_d = DSEL_S3;
      else               dsel_d = DSEL_DEF;
    end
  end

  // Default-slave FSM: ERR1 stalls the bus, ERR2 completes the ERROR response.
  always_comb begin
    ds_d = ds_q;
    unique case (ds_q)
      DS_IDLE: if (unmapped_capture) ds_d = DS_ERR1;
      DS_ERR1: ds_d = DS_ERR2;
      DS_ERR2: ds_d = unmapped_capture ? DS_ERR1 : DS_IDLE;
      default: ds_d = DS_IDLE;
    endcase
  end

  // State registers; reset abandons any data phase in flight, including a pending ERR2.
  always_ff @(posedge H_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (H_rst) begin
      dsel_q <= DSEL_NONE;
      ds_q   <= DS_IDLE;
    end else begin
      dsel_q <= dsel_d;
      ds_q   <= ds_d;
    end
  end

  // Return mux: zero-latency pass-through of the data-phase owner's signals.
  always_comb begin
    H_rdata_o = '0;
    H_ready_o = 1'b1;
    H_resp_o  = RESP_OKAY;
    unique case (dsel_q)
      DSEL_S1: begin
        H_rdata_o = H_rdata_s1;
        H_ready_o = H_ready_s1;
        H_resp_o  = H_resp_s1;
      end
      DSEL_S2: begin
        H_rdata_o = H_rdata_s2;
        H_ready_o = H_ready_s2;
        H_resp_o  = H_resp_s2;
      end
      DSEL_S3: begin
        H_rdata_o = H_rdata_s3;
        H_ready_o = H_ready_s3;
        H_resp_o  = H_resp_s3;
      end
      DSEL_DEF: begin
        H_ready_o = (ds_q == DS_ERR2);
        H_resp_o  = RESP_ERROR;
      end
      default: ;
    endcase
  end

endmodule
